rtc_read_cycle: RTL
===================

# rtc_read_cycle

Bus-cycle engine that performs one read transaction on the RTC chip's multiplexed address/data bus. It sits between the controller FSM and the bus pad multiplexer. The controller issues an 8-bit register address. The block drives the address phase, turns the bus around, strobes the read phase and returns the sampled byte. It is the read-side counterpart of the existing write-cycle path and shares the same bus pins through the pad mux.

## Interface
- PH, default 4: clock cycles per bus phase; legal range 1..255.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a read; sampled only in IDLE.
- addr  input  8  RTC register address; latched on the edge that accepts start.
- bus_in  input  8  data returned from the bidirectional bus pad.
- bus_out  output  8  value driven onto the bus when bus_oe=1.
- bus_oe  output  1  bus output enable (1 = block drives the bus).
- cs_n  output  1  RTC chip select, active low.
- rd_n  output  1  RTC read strobe, active low.
- wr_n  output  1  RTC write strobe, active low.
- ad_n  output  1  address/data select; 0 = address phase, 1 = data phase.
- busy  output  1  high while a transaction is in progress.
- done  output  1  single-cycle pulse when data_out is valid.
- data_out  output  8  last byte read; holds until the next read completes.

## Operation
- FSM states run in this order: IDLE, ADDR, ADDR_HOLD, TURN, READ, RECOVER, then back to IDLE.
- Every non-IDLE state lasts exactly PH cycles. An 8-bit phase counter runs 0..PH-1 and clears on each state change.
- IDLE
  - Outputs: cs_n=1, rd_n=1, wr_n=1, ad_n=1, bus_oe=0, busy=0.
  - start=1 latches addr into addr_q and moves to ADDR.
- ADDR: cs_n=0, wr_n=0, ad_n=0, bus_oe=1, bus_out=addr_q.
- ADDR_HOLD: wr_n=1; cs_n=0, ad_n=0, bus_oe=1 and bus_out=addr_q all stay unchanged.
- TURN: cs_n=1, ad_n=1, bus_oe=0 (bus released).
- READ: cs_n=0, rd_n=0, ad_n=1, bus_oe=0.
  - data_out loads bus_in on the edge that leaves READ.
  - rd_n is still low just before that edge.
- RECOVER
  - Outputs: cs_n=1, rd_n=1, wr_n=1, ad_n=1, bus_oe=0.
  - On exit: go to IDLE and set done=1 for one cycle.
- bus_out=0 in every state except ADDR and ADDR_HOLD.
- rd_n and wr_n are never low at the same time.
- bus_oe=1 never overlaps rd_n=0.
- All strobe, bus and status outputs are registered; none comes from a combinational path.

## Timing
- Reset values (applied immediately while reset=1)
  - State IDLE, phase counter 0, addr_q=0x00.
  - cs_n=1, rd_n=1, wr_n=1, ad_n=1, bus_oe=0, bus_out=0x00.
  - busy=0, done=0, data_out=0x00.
- E0 is the edge on which start is sampled high in IDLE.
- ADDR outputs and busy=1 take effect at E0.
- Phase boundaries are E0+PH, E0+2PH, E0+3PH and E0+4PH. data_out updates at E0+4PH.
- At E0+5PH: busy goes to 0 and done goes to 1. done returns to 0 at E0+5PH+1.
- Total latency is 5*PH cycles from E0 to done.
- A start sampled in the cycle where done=1 is accepted. That edge becomes the new E0, giving back-to-back reads with no idle gap.
- start while busy=1 is ignored and not queued.
- Changes on addr after E0 do not affect the transaction in flight.
- Reset asserted mid-transaction aborts it. Outputs go to reset values without waiting for a clock, and no done pulse is produced.
- PH=1 is legal: each phase lasts one cycle and latency is 5 cycles.

## Test plan
- Single read, PH=4, addr=0x21, bus model returns 0x59 while rd_n=0:
  - bus_out=0x21 with bus_oe=1 for cycles 1–8; wr_n low for cycles 1–4 only.
  - done pulses once at E0+20 with data_out=0x59; busy is high for exactly 20 cycles.
- Back-to-back reads:
  - Hold start=1 continuously with addr=0x22, then 0x23.
  - The second transaction begins on the done edge.
  - Two done pulses 20 cycles apart.
  - data_out shows the two distinct bus values.
- start pulses at E0+3 and E0+10 during a busy read: no extra transaction; exactly one done.
- Reset at E0+14 (inside READ): all outputs return to reset values at once, data_out=0x00, no done; a following start produces a normal 20-cycle read.
- Protocol checker over randomized starts and addresses, PH=1:
  - Never rd_n=0 and wr_n=0 together.
  - Never bus_oe=1 while rd_n=0.
  - Latency is always 5 cycles.

Source files
------------

// File: rtl/rtc_read_cycle.sv
// rtc_read_cycle: one read transaction on the RTC multiplexed address/data bus.
// Address phase, address hold, bus turnaround, read strobe, recovery; each
// phase lasts PH clocks. All pin-facing and status outputs are registered and
// are decoded from the next state so they change on the same edge as the FSM.
module rtc_read_cycle #(
    parameter int unsigned PH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] PH_LAST = CW'(PH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_HOLD = 3'd2,
        TURN      = 3'd3,
        READ      = 3'd4,
        RECOVER   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            done_q, done_d;

    logic [DW-1:0]   bus_out_q, bus_out_d;
    logic            bus_oe_q, bus_oe_d;
    logic            cs_n_q, cs_n_d;
    logic            rd_n_q, rd_n_d;
    logic            wr_n_q, wr_n_d;
    logic            ad_n_q, ad_n_d;
    logic            busy_q, busy_d;

    logic            phase_end;

    // Next state, phase counter, address latch, read-data capture and done.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        phase_end = (cnt_q == PH_LAST);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = ADDR;
                    addr_d  = addr;
                end
            end
            ADDR, ADDR_HOLD, TURN, READ, RECOVER: begin
                if (phase_end) begin
                    cnt_d = '0;
                    case (state_q)
                        ADDR:      state_d = ADDR_HOLD;
                        ADDR_HOLD: state_d = TURN;
                        TURN:      state_d = READ;
                        READ: begin
                            state_d = RECOVER;
                            data_d  = bus_in;
                        end
                        RECOVER: begin
                            // a start seen on the done edge chains straight into a new read
                            done_d = 1'b1;
                            if (start) begin
                                state_d = ADDR;
                                addr_d  = addr;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                        default:   state_d = IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin and status decode from the state being entered, so they register with it.
    always_comb begin
        bus_out_d = '0;
        bus_oe_d  = 1'b0;
        cs_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        ad_n_d    = 1'b1;
        busy_d    = (state_d != IDLE);

        case (state_d)
            ADDR: begin
                cs_n_d    = 1'b0;
                wr_n_d    = 1'b0;
                ad_n_d    = 1'b0;
                bus_oe_d  = 1'b1;
                bus_out_d = addr_d;
            end
            ADDR_HOLD: begin
                cs_n_d    = 1'b0;
                ad_n_d    = 1'b0;
                bus_oe_d  = 1'b1;
                bus_out_d = addr_d;
            end
            READ: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
            end
            default: begin
                bus_out_d = '0;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Output registers for the bus pins and busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_out_q <= '0;
            bus_oe_q  <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_n_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            ad_n_q    <= ad_n_d;
            busy_q    <= busy_d;
        end
    end

    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign cs_n     = cs_n_q;
    assign rd_n     = rd_n_q;
    assign wr_n     = wr_n_q;
    assign ad_n     = ad_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_q;

endmodule
